// File: rtl/imem_fetch_controller.sv
// Purpose: instruction-fetch sequencer. It drives the PC to the combinational imem and queues {instruction, pc} for decode.
// Latency: a fetched word is presented on out_* at the same edge that fetches it, so out_valid rises 1 cycle after reset release.
// Backpressure: the 2-entry buffer stalls fetch when it is full and out_ready is low. halt freezes fetch while the buffer drains.
// Ports: clk/reset (async active-low); Inst_Address/Instruction to imem; halt; redirect_valid/redirect_target;
//        out_valid/out_ready/out_instruction/out_pc to decode; fault/fault_addr report an illegal PC.
module imem_fetch_controller #(
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter int          IMEM_BYTES = 96,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_addr
);

    localparam logic [63:0] PC_MAX   = 64'(IMEM_BYTES - 4);
    localparam logic [1:0]  BUF_FULL = 2'(BUF_DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc;
    logic [1:0]  count;
    logic [31:0] tail_instr;
    logic [63:0] tail_pc;

    logic pc_legal;
    logic pop;
    logic push;
    logic fault_set;

    assign Inst_Address = pc;
    assign out_valid    = (count != 2'd0);
    assign fault        = (state_q == FAULT);

    assign pc_legal = (pc[1:0] == 2'b00) && (pc <= PC_MAX);
    assign pop      = out_valid && out_ready;

    // A redirect overrides everything else. Otherwise an illegal PC seen in RUN parks the fetcher in FAULT.
    always_comb begin
        state_d   = state_q;
        fault_set = 1'b0;
        push      = 1'b0;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (!pc_legal) begin
                state_d   = FAULT;
                fault_set = 1'b1;
            end else if (!halt && (count < BUF_FULL || pop)) begin
                push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The head entry is held in the out_* registers and the second entry sits in tail_*.
    // The head keeps its last value once it drains, which is why the out_* registers are never cleared on a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc              <= PC_RESET;
            count           <= 2'd0;
            out_instruction <= 32'd0;
            out_pc          <= 64'd0;
            tail_instr      <= 32'd0;
            tail_pc         <= 64'd0;
            fault_addr      <= 64'd0;
        end else if (redirect_valid) begin
            // Flush: any pop this cycle was still taken by decode, but nothing remains buffered.
            pc    <= redirect_target;
            count <= 2'd0;
        end else begin
            if (push) begin
                pc <= pc + 64'd4;
            end
            if (fault_set) begin
                fault_addr <= pc;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_instruction <= Instruction;
                        out_pc          <= pc;
                    end else begin
                        tail_instr <= Instruction;
                        tail_pc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_instruction <= tail_instr;
                        out_pc          <= tail_pc;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // The buffer stays at the same occupancy. The new word either becomes the head or moves in behind it.
                    if (count == 2'd2) begin
                        out_instruction <= tail_instr;
                        out_pc          <= tail_pc;
                        tail_instr      <= Instruction;
                        tail_pc         <= pc;
                    end else begin
                        out_instruction <= Instruction;
                        out_pc          <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
